// File: rtl/div_sequencer.sv
// Radix-2 restoring divider with its own sequencing FSM for DIV/DIVU in execute.
// Quotient lands in lo, remainder in hi, announced by a one-cycle valid pulse.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             valid,
  output logic             busy,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Magnitude of a two's-complement operand when signed mode is active.
  function automatic logic [WIDTH-1:0] magnitude(input logic en, input logic [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] sx;
    sx = $signed(x);
    if (en && sx < 0)
      return WIDTH'(-sx);
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] x);
    return neg ? WIDTH'(-x) : x;
  endfunction

  assign abs_a = magnitude(sign, a);
  assign abs_b = magnitude(sign, b);

  // One restoring step: remainder stays below the divisor, so the trial
  // difference's top bit alone tells whether the subtraction fits.
  always_comb begin
    partial = {rem, quo[WIDTH-1]};
    diff    = partial - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = partial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign busy  = (state != IDLE);
  assign valid = (state == DONE) && !cancel;
  assign stall = !cancel && (((state == IDLE) && start) || (state == RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (b == '0) begin
              lo    <= '1;
              hi    <= a;
              state <= DONE;
            end else begin
              cnt   <= CNT_W'(WIDTH);
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              lo    <= apply_sign(neg_q, quo_nxt);
              hi    <= apply_sign(neg_r, rem_nxt);
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operands captured every idle cycle, iterated while running.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      rem   <= '0;
      quo   <= abs_a;
      dvs   <= abs_b;
      neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sign & a[WIDTH-1];
    end else if (state == RUN) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule
